// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC sample accumulator and its neighbours:
// the run-control state encoding and the width helpers used to size the
// hamming-weight and sum datapaths.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width needed to hold a pop-count of an n-tap delay line (0..n inclusive).
  function automatic int hw_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // Width of a sum of 2^max_log2 hamming-weight samples; cannot overflow.
  function automatic int sum_width(input int n, input int max_log2);
    return hw_width(n) + max_log2;
  endfunction

endpackage

// File: rtl/tdc_sample_accum_if.sv
// Control, sample and result bundle of the TDC sample accumulator.
// The master side drives run control and samples, the slave side returns
// status and results.
interface tdc_sample_accum_if
  import tdc_pkg::*;
#(
  parameter int N                = 64,
  parameter int MAX_LOG2_SAMPLES = 8,
  parameter int LOG2_W           = $clog2(MAX_LOG2_SAMPLES + 1)
) ();

  localparam int HW_W  = hw_width(N);
  localparam int SUM_W = sum_width(N, MAX_LOG2_SAMPLES);

  logic              en;
  logic              start;
  logic              abort;
  logic [LOG2_W-1:0] n_log2;
  logic [HW_W-1:0]   hw;
  logic              val_in;
  logic              busy;
  logic              val_out;
  logic [SUM_W-1:0]  sum;
  logic [HW_W-1:0]   avg;
  logic [HW_W-1:0]   hw_min;
  logic [HW_W-1:0]   hw_max;
  logic              aborted;

  modport master (
    output en, start, abort, n_log2, hw, val_in,
    input  busy, val_out, sum, avg, hw_min, hw_max, aborted
  );

  modport slave (
    input  en, start, abort, n_log2, hw, val_in,
    output busy, val_out, sum, avg, hw_min, hw_max, aborted
  );

endinterface

// File: rtl/tdc_minmax.sv
// Running minimum / maximum tracker for one measurement run.
// Clear primes min with all-ones and max with zero so the first valid
// sample always replaces both. Enable gating is done by the caller.
module tdc_minmax #(
  parameter int HW_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clear,
  input  logic            i_valid,
  input  logic [HW_W-1:0] i_sample,
  output logic [HW_W-1:0] o_min,
  output logic [HW_W-1:0] o_max
);

  logic [HW_W-1:0] r_min;
  logic [HW_W-1:0] r_max;

  // Track the extremes; clear wins over a coincident sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min <= '0;
      r_max <= '0;
    end else if (i_clear) begin
      r_min <= '1;
      r_max <= '0;
    end else if (i_valid) begin
      if (i_sample < r_min) r_min <= i_sample;
      if (i_sample > r_max) r_max <= i_sample;
    end
  end

  assign o_min = r_min;
  assign o_max = r_max;

endmodule

// File: rtl/tdc_sample_accum.sv
// Accumulates 2^n_log2 hamming-weight samples from a TDC pop-count and
// reports sum, average (shift, no divider), minimum and maximum. Results
// are registered on the edge that accepts the last sample, so they and the
// val_out pulse (the DONE state) appear exactly one cycle after it.
module tdc_sample_accum
  import tdc_pkg::*;
#(
  parameter int N                = 64,
  parameter int MAX_LOG2_SAMPLES = 8,
  parameter int LOG2_W           = $clog2(MAX_LOG2_SAMPLES + 1)
) (
  input logic                clk,
  input logic                rst,
  tdc_sample_accum_if.slave  bus
);

  localparam int HW_W  = hw_width(N);
  localparam int SUM_W = sum_width(N, MAX_LOG2_SAMPLES);
  localparam int CNT_W = MAX_LOG2_SAMPLES + 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LOG2_W-1:0] r_n_log2;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_last_cnt;
  logic [SUM_W-1:0]  r_acc;
  logic [SUM_W-1:0]  w_acc_nxt;
  logic [SUM_W-1:0]  r_sum;
  logic [HW_W-1:0]   r_avg;
  logic [HW_W-1:0]   r_min;
  logic [HW_W-1:0]   r_max;
  logic              r_aborted;
  logic [HW_W-1:0]   w_run_min;
  logic [HW_W-1:0]   w_run_max;
  logic [HW_W-1:0]   w_fin_min;
  logic [HW_W-1:0]   w_fin_max;
  logic              w_start_run;
  logic              w_take;
  logic              w_last;
  logic              w_abort;

  // Clamp a requested exponent to the largest run the accumulator supports.
  function automatic logic [LOG2_W-1:0] sat_log2(input logic [LOG2_W-1:0] v);
    if (int'(v) > MAX_LOG2_SAMPLES) return LOG2_W'(MAX_LOG2_SAMPLES);
    return v;
  endfunction

  // Mux-based right shift by the latched exponent; the quotient of a full
  // run always fits the hamming-weight width.
  function automatic logic [HW_W-1:0] shr_avg(input logic [SUM_W-1:0] v,
                                              input logic [LOG2_W-1:0] sh);
    logic [SUM_W-1:0] t;
    t = v;
    for (int i = 0; i <= MAX_LOG2_SAMPLES; i++) begin
      if (sh == LOG2_W'(i)) t = v >> i;
    end
    return t[HW_W-1:0];
  endfunction

  assign w_start_run = bus.en && (r_state == IDLE) && bus.start;
  assign w_abort     = bus.en && (r_state == ACCUM) && bus.abort;
  assign w_take      = bus.en && (r_state == ACCUM) && !bus.abort && bus.val_in;
  assign w_last_cnt  = (CNT_W'(1) << r_n_log2) - CNT_W'(1);
  assign w_last      = w_take && (r_cnt == w_last_cnt);
  assign w_acc_nxt   = r_acc + SUM_W'(bus.hw);

  // The final sample is folded in here so results land with the DONE entry.
  assign w_fin_min = (bus.hw < w_run_min) ? bus.hw : w_run_min;
  assign w_fin_max = (bus.hw > w_run_max) ? bus.hw : w_run_max;

  tdc_minmax #(
    .HW_W (HW_W)
  ) u_minmax (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_start_run),
    .i_valid  (w_take),
    .i_sample (bus.hw),
    .o_min    (w_run_min),
    .o_max    (w_run_max)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; nothing moves while en is low.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_run) w_state_nxt = ACCUM;
      ACCUM: begin
        if (w_abort)     w_state_nxt = IDLE;
        else if (w_last) w_state_nxt = DONE;
      end
      DONE:    if (bus.en) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Run bookkeeping and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n_log2  <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_sum     <= '0;
      r_avg     <= '0;
      r_min     <= '0;
      r_max     <= '0;
      r_aborted <= 1'b0;
    end else begin
      if (w_start_run) begin
        r_n_log2 <= sat_log2(bus.n_log2);
        r_cnt    <= '0;
        r_acc    <= '0;
      end else if (w_take) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_last) begin
        r_sum     <= w_acc_nxt;
        r_avg     <= shr_avg(w_acc_nxt, r_n_log2);
        r_min     <= w_fin_min;
        r_max     <= w_fin_max;
        r_aborted <= 1'b0;
      end
      if (w_abort) r_aborted <= 1'b1;
    end
  end

  assign bus.busy    = (r_state != IDLE);
  assign bus.val_out = (r_state == DONE);
  assign bus.sum     = r_sum;
  assign bus.avg     = r_avg;
  assign bus.hw_min  = r_min;
  assign bus.hw_max  = r_max;
  assign bus.aborted = r_aborted;

endmodule

// File: tb/tb_tdc_sample_accum.sv
// Directed bench for tdc_sample_accum: expected results are queued when a
// run's final sample is driven; a negedge monitor pops and compares them
// whenever val_out is seen, including the cycle on which it appears.
module tb_tdc_sample_accum;
  import tdc_pkg::*;

  localparam int N      = 64;
  localparam int MAXL   = 8;
  localparam int LOG2_W = $clog2(MAXL + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct {
    logic [14:0] sum;
    logic [6:0]  avg;
    logic [6:0]  mn;
    logic [6:0]  mx;
    logic        ab;
    int          at;
  } exp_t;

  exp_t sb[$];

  tdc_sample_accum_if #(.N(N), .MAX_LOG2_SAMPLES(MAXL), .LOG2_W(LOG2_W)) bus ();

  tdc_sample_accum #(.N(N), .MAX_LOG2_SAMPLES(MAXL), .LOG2_W(LOG2_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected result of a run whose final sample is about to be driven.
  task automatic push(input int s, input int a, input int mn, input int mx);
    exp_t e;
    e.sum = 15'(s); e.avg = 7'(a); e.mn = 7'(mn); e.mx = 7'(mx);
    e.ab = 1'b0; e.at = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic begin_run(input int n);
    bus.n_log2 = LOG2_W'(n);
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic send(input int h);
    bus.hw     = 7'(h);
    bus.val_in = 1'b1;
    tick();
    bus.val_in = 1'b0;
  endtask

  // Monitor: every val_out must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.val_out === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_val_out: got val_out=1 with sum=%0d, expected no pulse (cycle %0d)",
                 bus.sum, cyc);
      end else begin
        e = sb.pop_front();
        check("val_out_cycle", cyc, e.at);
        check("sum",     32'(bus.sum),    32'(e.sum));
        check("avg",     32'(bus.avg),    32'(e.avg));
        check("hw_min",  32'(bus.hw_min), 32'(e.mn));
        check("hw_max",  32'(bus.hw_max), 32'(e.mx));
        check("aborted", 32'(bus.aborted), 32'(e.ab));
      end
    end
  end

  initial begin
    bus.en = 1'b1; bus.start = 1'b0; bus.abort = 1'b0;
    bus.n_log2 = '0; bus.hw = '0; bus.val_in = 1'b0;
    tick(); tick();
    check("rst_busy",    32'(bus.busy),    0);
    check("rst_val_out", 32'(bus.val_out), 0);
    check("rst_sum",     32'(bus.sum),     0);
    check("rst_min",     32'(bus.hw_min),  0);
    check("rst_aborted", 32'(bus.aborted), 0);
    rst = 1'b0;
    tick();

    // Four consecutive samples, 2^2 run.
    begin_run(2);
    check("busy_accum", 32'(bus.busy), 1);
    send(10); send(20); send(30);
    push(100, 25, 10, 40);
    send(40);
    check("busy_done", 32'(bus.busy), 1);
    tick();
    check("busy_idle", 32'(bus.busy), 0);

    // Single-sample run; the sample coincident with start must be ignored.
    bus.hw = 7'd5; bus.val_in = 1'b1;
    begin_run(0);
    push(63, 63, 63, 63);
    send(63);
    tick();

    // 8 samples of 5 spread over 20 cycles, stray starts and an en-low sample.
    begin_run(3);
    for (int k = 0; k < 20; k++) begin
      bus.val_in = (k inside {0, 3, 4, 5, 7, 9, 12, 15, 19});
      bus.en     = (k != 5);
      bus.start  = (k inside {2, 10});
      bus.hw     = !bus.val_in ? 7'd99 : ((k == 5) ? 7'd50 : 7'd5);
      if (k == 19) push(40, 5, 5, 5);
      tick();
    end
    bus.val_in = 1'b0; bus.en = 1'b1; bus.start = 1'b0;
    tick();

    // Abort while idle is ignored.
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("idle_abort_aborted", 32'(bus.aborted), 0);
    check("idle_abort_busy",    32'(bus.busy),    0);

    // Abort after two of four samples; abort beats a coincident sample.
    begin_run(2);
    send(7); send(8);
    bus.abort = 1'b1; bus.hw = 7'd9; bus.val_in = 1'b1;
    tick();
    bus.abort = 1'b0; bus.val_in = 1'b0;
    check("abort_busy",    32'(bus.busy),    0);
    check("abort_flag",    32'(bus.aborted), 1);
    check("abort_sum",     32'(bus.sum),     40);
    check("abort_avg",     32'(bus.avg),     5);
    check("abort_min",     32'(bus.hw_min),  5);
    check("abort_max",     32'(bus.hw_max),  5);
    tick();

    // Following full run clears aborted.
    begin_run(2);
    send(1); send(2); send(3);
    push(12, 3, 1, 6);
    send(6);
    tick();
    check("rerun_aborted", 32'(bus.aborted), 0);

    // Oversized exponent saturates to 256 samples; mid-run n_log2 change ignored.
    begin_run(15);
    for (int i = 0; i < 256; i++) begin
      if (i == 100) bus.n_log2 = LOG2_W'(1);
      if (i == 255) push(16384, 64, 64, 64);
      send(64);
    end
    tick();

    // Asynchronous reset mid-run.
    begin_run(2);
    send(2); send(3);
    #3 rst = 1'b1;
    #1;
    check("arst_busy",    32'(bus.busy),    0);
    check("arst_val_out", 32'(bus.val_out), 0);
    check("arst_sum",     32'(bus.sum),     0);
    check("arst_avg",     32'(bus.avg),     0);
    check("arst_min",     32'(bus.hw_min),  0);
    check("arst_max",     32'(bus.hw_max),  0);
    tick();
    rst = 1'b0;
    tick();

    // Normal operation after reset; odd sum rounds down.
    begin_run(1);
    send(3);
    push(7, 3, 3, 4);
    send(4);
    tick(); tick(); tick();

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tdc_sample_accum.md
TDC_SAMPLE_ACCUM -- requirements
Module: tdc_sample_accum

Interface
REQ-001 Parameter N, default 64: delay-line length; hamming-weight width HW_W = $clog2(N)+1.
REQ-002 Parameter MAX_LOG2_SAMPLES, default 8: largest supported sample-count exponent; SUM_W = HW_W + MAX_LOG2_SAMPLES.
REQ-003 Parameter LOG2_W, default $clog2(MAX_LOG2_SAMPLES+1): width of the runtime exponent port.
REQ-004 Port clk, input, 1: single clock; all state on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port en, input, 1: clock enable; when low all state holds.
REQ-007 Port start, input, 1: single-cycle request to begin a measurement run.
REQ-008 Port abort, input, 1: synchronous cancel of a run in progress.
REQ-009 Port n_log2, input, LOG2_W: run length exponent; samples per run = 2^n_log2.
REQ-010 Port hw, input, HW_W: hamming-weight sample from the TDC pop-count.
REQ-011 Port val_in, input, 1: hw is valid this cycle.
REQ-012 Port busy, output, 1: run in progress.
REQ-013 Port val_out, output, 1: one-cycle pulse when results update.
REQ-014 Port sum, output, SUM_W: sum of the run's samples.
REQ-015 Port avg, output, HW_W: floor(sum / 2^n_log2_latched).
REQ-016 Port hw_min / hw_max, output, HW_W each: min/max sample of the run.
REQ-017 Port aborted, output, 1: last run ended by abort.

Function
REQ-018 FSM states IDLE, ACCUM, DONE; every transition requires en=1.
REQ-019 IDLE: start=1 -> ACCUM; n_log2 is latched (saturated to MAX_LOG2_SAMPLES when larger), the accumulator is cleared to 0, the running minimum is set to all-ones, the running maximum is set to 0, and the sample counter is cleared to 0.
REQ-020 val_in coincident with the start cycle is not counted; counting begins the next cycle.
REQ-021 ACCUM: each cycle with val_in=1 adds hw to the accumulator, updates the running minimum and maximum, and increments the sample counter.
REQ-022 ACCUM: when the sample counter reaches 2^n_log2_latched-1 and val_in=1 in the same cycle -> DONE; that last sample is included.
REQ-023 DONE: sum, avg, hw_min and hw_max register the final values in one cycle, val_out pulses for that cycle, aborted is cleared to 0, and the FSM returns to IDLE; latency from the last sample to val_out is exactly 1 cycle.
REQ-024 ACCUM: abort=1 -> IDLE; outputs hold their previous results, aborted is set to 1, and no val_out pulse is generated; abort has priority over a sample in the same cycle.
REQ-025 start while busy=1 is ignored; abort in IDLE is ignored; val_in in IDLE or DONE is ignored.
REQ-026 busy=1 in ACCUM and DONE, and 0 in IDLE.
REQ-027 n_log2=0 gives a run of one sample: avg = sum = hw_min = hw_max = that sample.
REQ-028 The accumulator cannot overflow by construction: SUM_W holds 2^MAX_LOG2_SAMPLES × (2^HW_W − 1).
REQ-029 Result outputs hold their values between runs; an n_log2 change mid-run does not affect the run in progress.
REQ-030 en=0 during ACCUM pauses the run: samples presented while en=0 are dropped and the sample counter holds.

Reset
REQ-031 rst=1 asynchronously forces the following state: FSM=IDLE; busy, val_out and aborted = 0; sum, avg, hw_min and hw_max = 0; internal counter, accumulator and latched n_log2 = 0.
REQ-032 Reset during ACCUM discards the partial run with no val_out pulse.
REQ-033 Release of reset takes effect on the next rising clk edge.

Structure
REQ-034 Package tdc_pkg holds the FSM state enum (IDLE, ACCUM, DONE) and the width helper functions for HW_W and SUM_W, shared with the pop-count block.
REQ-035 A single sub-module tdc_minmax (HW_W parameter; clear, sample and valid inputs; min and max registered outputs) is instantiated once.
REQ-036 avg is a constant-width right shift by the latched exponent (mux-based shifter); no divider is used.

Verification
REQ-037 N=64, n_log2=2, start, then hw=10,20,30,40 on consecutive cycles with val_in=1 -> val_out 1 cycle after 40; sum=100, avg=25, hw_min=10, hw_max=40.
REQ-038 n_log2=0, start, hw=63 with val_in=1 -> sum=63, avg=63, hw_min=hw_max=63, val_out once, aborted=0.
REQ-039 n_log2=3 with gaps in val_in (8 valid samples of 5 spread over 20 cycles) -> sum=40, avg=5; start pulses inside the run are ignored.
REQ-040 Abort after 2 of 4 samples -> no val_out pulse, aborted=1, previous results unchanged; the next full run clears aborted.
REQ-041 n_log2=15 with MAX_LOG2_SAMPLES=8 -> run of 256 samples of hw=64 -> sum=16384, avg=64.
REQ-042 rst asserted mid-run between clock edges -> busy=0 immediately, all outputs 0, no val_out pulse.
